// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks outstanding register writes and raises stall for unready D-stage operands
// Ports: clk, reset (sync, active-high); issue_valid/issue_rd/issue_tnew record a promised write;
// retire_valid/retire_rd retire it at W; rs/rt with *_used/*_tuse describe D-stage reads;
// stall, busy_mask (per-register outstanding flag) and sticky err are outputs.
module reg_scoreboard #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [1:0]  issue_tnew,
  input  logic        retire_valid,
  input  logic [4:0]  retire_rd,
  input  logic [4:0]  rs,
  input  logic        rs_used,
  input  logic [1:0]  rs_tuse,
  input  logic [4:0]  rt,
  input  logic        rt_used,
  input  logic [1:0]  rt_tuse,
  output logic        stall,
  output logic [31:0] busy_mask,
  output logic        err
);
  localparam logic [1:0] CMAX = 2'(MAX_INFLIGHT);
  logic [31:0][1:0] cnt, rdy, cnt_n, rdy_n;
  logic iss, ret, ovf, udf;
  // Loop starts at 1 so $0 keeps cnt/rdy at zero and its events are silently ignored.
  always_comb begin
    cnt_n = '0;
    rdy_n = '0;
    ovf = 1'b0;
    udf = 1'b0;
    iss = 1'b0;
    ret = 1'b0;
    for (int r = 1; r < 32; r++) begin
      iss = issue_valid && issue_rd == 5'(r);
      ret = retire_valid && retire_rd == 5'(r);
      cnt_n[r] = (iss && !ret) ? (cnt[r] == CMAX ? CMAX : cnt[r] + 2'd1) :
                 (ret && !iss) ? (cnt[r] == 2'd0 ? 2'd0 : cnt[r] - 2'd1) : cnt[r];
      // The youngest writer defines readiness; an idle register is always ready.
      rdy_n[r] = cnt_n[r] == 2'd0 ? 2'd0 : iss ? issue_tnew :
                 (rdy[r] == 2'd0 ? 2'd0 : rdy[r] - 2'd1);
      ovf = ovf | (iss && !ret && cnt[r] == CMAX);
      udf = udf | (ret && !iss && cnt[r] == 2'd0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      rdy <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_n;
      rdy <= rdy_n;
      err <= err | ovf | udf;
    end
  end
  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < 32; r++) busy_mask[r] = cnt[r] != 2'd0;
  end
  assign stall = (rs_used && rs != 5'd0 && cnt[rs] != 2'd0 && rdy[rs] > rs_tuse) ||
                 (rt_used && rt != 5'd0 && cnt[rt] != 2'd0 && rdy[rt] > rt_tuse);
endmodule
